m_fetch_queue: RTL
==================

# m_fetch_queue

Instruction-fetch front end that sits directly upstream of the processor's ID stage. It owns the program counter and issues word reads to a synchronous-read instruction memory (one-cycle read latency). It buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake. Branch redirects flush the queue and discard any in-flight read; halt stops new fetches while the queue drains.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- AW, 12: instruction-memory word-address width
- RESET_PC, 32'h0: byte PC loaded at reset
- w_clk  in  1  clock; all state updates on rising edge
- w_rst_n  in  1  reset, asynchronous, active-low
- w_halt  in  1  1 = issue no new fetches
- w_redir  in  1  1 = flush queue, restart fetch at w_redir_pc
- w_redir_pc  in  32  redirect target, byte address
- w_imem_req  out  1  read issued this cycle
- w_imem_addr  out  AW  word address, = r_pc[AW+1:2]
- w_imem_data  in  32  read data, valid the cycle after req
- w_out_valid  out  1  head entry available
- w_out_ready  in  1  decode accepts head
- w_out_ir  out  32  head instruction
- w_out_pc  out  32  head PC
- w_out_pc4  out  32  head PC + 4
- r_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: r_pc (32), r_inflight (1), r_inflight_pc (32), FIFO of {ir, pc}.
- Issue: w_imem_req = rst_n & ~w_halt & ~w_redir & (r_count + r_inflight < DEPTH). On issue: r_pc <= r_pc+4 (mod 2^32), r_inflight <= 1, r_inflight_pc <= r_pc; otherwise r_inflight <= 0.
- Return: if r_inflight was set the previous cycle, w_imem_data with r_inflight_pc is pushed this cycle.
- Pop: w_out_valid & w_out_ready.
- Push and pop in the same cycle: count unchanged. The credit check guarantees push never occurs when full.
- Output: w_out_valid = (r_count != 0). w_out_ir, w_out_pc, and w_out_pc4 show the head entry; all read 0 while invalid. There is no bypass: an entry pushed when empty is visible the next cycle.
- Redirect (highest priority): r_pc <= w_redir_pc, FIFO cleared (r_count <= 0), r_inflight <= 0. The returning data of any prior read is dropped. No push, pop, or issue happens in that cycle.
- Halt: no issue. An in-flight read still completes and is pushed, and the queue drains normally. When halt deasserts, fetch resumes at r_pc. A redirect during halt loads r_pc only.
- Address wraps naturally through the truncation to r_pc[AW+1:2].

## Timing
- Reset values: r_pc = RESET_PC, r_count = 0, r_inflight = 0, w_out_valid = 0, w_out_ir/pc/pc4 = 0, w_imem_req = 0 while w_rst_n = 0. FIFO pointers = 0.
- Reset asserted mid-operation: all state clears immediately (async); the in-flight read is lost.
- Fetch latency: req in cycle t, push at end of t+1, w_out_valid in t+2.
- Redirect in cycle t: first req at the target in t+1, valid at the target in t+3.
- Steady state with w_out_ready = 1 sustains 1 instruction/cycle.
- w_out_ready = 0 fills the queue to DEPTH, then req stays 0 until a pop.

## Structure
- Shared header or package: opcode constants (NOP, BEQ, BNE, HALT), instruction width 32, RESET_PC default.
- One sub-module, m_fifo_sync: parameterized synchronous FIFO with push, pop, flush, count, and async active-low reset.
- The PC, in-flight tracking, and issue logic live in m_fetch_queue.

## Test plan
- Reset release with imem[i] = i+0x100 and ready = 1: req from cycle 1; outputs pc = 0,4,8,… with ir = 0x100,0x101,… back-to-back, pc4 = pc+4.
- Hold ready = 0: r_count saturates at 4 and req drops. Raise ready: four queued entries, then the stream continues with no PC gap or duplicate.
- Redirect to 0x40 while count = 3 and a read is in flight: count goes to 0 the next cycle, the stale data is not pushed, and the first output is pc = 0x40 exactly 3 cycles after the redirect.
- Assert halt with count = 2 and a read in flight: exactly 3 entries are delivered and no further req. Deassert halt: fetch resumes at the next sequential PC.
- Simultaneous redirect with w_out_valid & w_out_ready: no pop occurs and the queue is flushed.
- Assert w_rst_n = 0 mid-stream with no clock edge: outputs go to 0 and count to 0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/m_fetch_queue_pkg.sv
// Shared types and constants for the fetch front end.
// Opcodes, instruction width and the queue entry bundle.
package m_fetch_queue_pkg;

  localparam int INSN_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  localparam logic [31:0] OP_NOP  = 32'h0000_0013;
  localparam logic [31:0] OP_HALT = 32'h0010_0073;
  localparam logic [6:0]  OPC_BR  = 7'b110_0011;
  localparam logic [2:0]  F3_BEQ  = 3'b000;
  localparam logic [2:0]  F3_BNE  = 3'b001;

  typedef struct packed {
    logic [INSN_W-1:0] ir;
    logic [31:0]       pc;
  } fq_entry_t;

endpackage

// File: rtl/m_fetch_queue_if.sv
// Fetch front end bundle: control, imem port and decode handshake.
// master = fetch queue view, slave = surrounding core view.
interface m_fetch_queue_if
  import m_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 12
);
  logic                    w_halt;
  logic                    w_redir;
  logic [31:0]             w_redir_pc;
  logic                    w_imem_req;
  logic [AW-1:0]           w_imem_addr;
  logic [INSN_W-1:0]       w_imem_data;
  logic                    w_out_valid;
  logic                    w_out_ready;
  logic [INSN_W-1:0]       w_out_ir;
  logic [31:0]             w_out_pc;
  logic [31:0]             w_out_pc4;
  logic [$clog2(DEPTH):0]  r_count;

  modport master (
    input  w_halt, w_redir, w_redir_pc,
    input  w_imem_data, w_out_ready,
    output w_imem_req, w_imem_addr,
    output w_out_valid, w_out_ir,
    output w_out_pc, w_out_pc4, r_count
  );

  modport slave (
    output w_halt, w_redir, w_redir_pc,
    output w_imem_data, w_out_ready,
    input  w_imem_req, w_imem_addr,
    input  w_out_valid, w_out_ir,
    input  w_out_pc, w_out_pc4, r_count
  );

endinterface

// File: rtl/m_fifo_sync.sv
// Synchronous FIFO with flush and occupancy count.
// Head is read combinationally; no write-through bypass.
module m_fifo_sync #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   w_clk,
  input  logic                   w_rst_n,
  input  logic                   w_push,
  input  logic                   w_pop,
  input  logic                   w_flush,
  input  logic [W-1:0]           w_din,
  output logic [W-1:0]           w_dout,
  output logic [$clog2(DEPTH):0] r_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;

  assign w_dout = r_mem[r_rd];

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_push && !w_flush) r_mem[r_wr] <= w_din;
  end

endmodule

// File: rtl/m_fetch_queue.sv
// Fetch front end: PC, one-deep read tracking, instruction queue.
// Issue is credit-limited so a returning read always has a slot.
module m_fetch_queue
  import m_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 12,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  m_fetch_queue_if.master fq
);
  logic [31:0]            r_pc;
  logic                   r_inflight;
  logic [31:0]            r_inflight_pc;
  logic [$clog2(DEPTH):0] w_cnt;
  logic                   w_credit;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  fq_entry_t              w_in;
  fq_entry_t              w_head;

  assign w_credit = (int'(w_cnt) + int'(r_inflight)) < DEPTH;
  assign w_issue  = w_rst_n & ~fq.w_halt & ~fq.w_redir & w_credit;
  assign w_push   = r_inflight & ~fq.w_redir;
  assign w_pop    = fq.w_out_valid & fq.w_out_ready & ~fq.w_redir;

  assign w_in.ir  = fq.w_imem_data;
  assign w_in.pc  = r_inflight_pc;

  assign fq.w_imem_req  = w_issue;
  assign fq.w_imem_addr = r_pc[AW+1:2];
  assign fq.r_count     = w_cnt;
  assign fq.w_out_valid = (w_cnt != '0);
  assign fq.w_out_ir    = fq.w_out_valid ? w_head.ir : '0;
  assign fq.w_out_pc    = fq.w_out_valid ? w_head.pc : '0;
  assign fq.w_out_pc4   = fq.w_out_valid ? w_head.pc + 32'd4 : '0;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (fq.w_redir) begin
      r_pc       <= fq.w_redir_pc;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + 32'd4;
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  m_fifo_sync #(
    .DEPTH (DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fifo (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_push  (w_push),
    .w_pop   (w_pop),
    .w_flush (fq.w_redir),
    .w_din   (w_in),
    .w_dout  (w_head),
    .r_count (w_cnt)
  );

endmodule
